// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - host command codes, operand addresses and FSM encoding
package sys_ctrl_pkg;

  localparam logic [7:0] RF_WR_CMD    = 8'hAA;
  localparam logic [7:0] RF_RD_CMD    = 8'hBB;
  localparam logic [7:0] ALU_W_OP_CMD = 8'hCC;
  localparam logic [7:0] ALU_N_OP_CMD = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_ADDR  = 4'd1;
  localparam logic [3:0] ST_WR_DATA  = 4'd2;
  localparam logic [3:0] ST_RD_ADDR  = 4'd3;
  localparam logic [3:0] ST_RD_WAIT  = 4'd4;
  localparam logic [3:0] ST_OPA      = 4'd5;
  localparam logic [3:0] ST_OPB      = 4'd6;
  localparam logic [3:0] ST_FUN      = 4'd7;
  localparam logic [3:0] ST_ALU_WAIT = 4'd8;
  localparam logic [3:0] ST_TX_LSB   = 4'd9;
  localparam logic [3:0] ST_TX_GAP   = 4'd10;
  localparam logic [3:0] ST_TX_MSB   = 4'd11;
  localparam logic [3:0] ST_TX_END   = 4'd12;

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// rtl/sys_cmd_ctrl_if.sv - RX/RF/ALU/TX signal bundle of the command controller
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]    RX_P_DATA;
  logic                     RX_D_VLD;
  logic [ADDR_WIDTH-1:0]    RF_ADDR;
  logic                     RF_WR_EN;
  logic [DATA_WIDTH-1:0]    RF_WR_DATA;
  logic                     RF_RD_EN;
  logic [DATA_WIDTH-1:0]    RF_RD_DATA;
  logic                     RF_RD_DATA_VLD;
  logic [ALU_FUN_WIDTH-1:0] ALU_FUN;
  logic                     ALU_EN;
  logic [2*DATA_WIDTH-1:0]  ALU_OUT;
  logic                     ALU_OUT_VLD;
  logic [DATA_WIDTH-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     TX_BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - UART host command decoder and response sequencer
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  sys_cmd_ctrl_if.master bus
);

  logic [3:0]               state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    lsb_q, lsb_d, msb_q, msb_d;
  logic                     two_q, two_d;
  logic                     wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d, tx_vld_q, tx_vld_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d, tx_data_q, tx_data_d;
  logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lsb_d     = lsb_q;
    msb_d     = msb_q;
    two_d     = two_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    wr_data_d = wr_data_q;
    fun_d     = fun_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: if (bus.RX_D_VLD) begin
        case (bus.RX_P_DATA)
          RF_WR_CMD:    state_d = ST_WR_ADDR;
          RF_RD_CMD:    state_d = ST_RD_ADDR;
          ALU_W_OP_CMD: state_d = ST_OPA;
          ALU_N_OP_CMD: state_d = ST_FUN;
          default:      state_d = ST_IDLE;
        endcase
      end
      ST_WR_ADDR: if (bus.RX_D_VLD) begin
        addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = ST_WR_DATA;
      end
      ST_WR_DATA: if (bus.RX_D_VLD) begin
        wr_en_d   = 1'b1;
        wr_data_d = bus.RX_P_DATA;
        state_d   = ST_IDLE;
      end
      ST_RD_ADDR: if (bus.RX_D_VLD) begin
        addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
        state_d = ST_RD_WAIT;
      end
      // With the transmitter idle the first byte leaves straight from the wait
      // state, giving one cycle from result-valid to TX_D_VLD.
      ST_RD_WAIT: if (bus.RF_RD_DATA_VLD) begin
        lsb_d   = bus.RF_RD_DATA;
        two_d   = 1'b0;
        state_d = ST_TX_LSB;
        if (!bus.TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = bus.RF_RD_DATA;
          state_d   = ST_TX_END;
        end
      end
      ST_OPA: if (bus.RX_D_VLD) begin
        addr_d    = ADDR_WIDTH'(OPA_ADDR);
        wr_en_d   = 1'b1;
        wr_data_d = bus.RX_P_DATA;
        state_d   = ST_OPB;
      end
      ST_OPB: if (bus.RX_D_VLD) begin
        addr_d    = ADDR_WIDTH'(OPB_ADDR);
        wr_en_d   = 1'b1;
        wr_data_d = bus.RX_P_DATA;
        state_d   = ST_FUN;
      end
      ST_FUN: if (bus.RX_D_VLD) begin
        alu_en_d = 1'b1;
        fun_d    = bus.RX_P_DATA[ALU_FUN_WIDTH-1:0];
        state_d  = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: if (bus.ALU_OUT_VLD) begin
        lsb_d   = bus.ALU_OUT[DATA_WIDTH-1:0];
        msb_d   = bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
        two_d   = 1'b1;
        state_d = ST_TX_LSB;
        if (!bus.TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = bus.ALU_OUT[DATA_WIDTH-1:0];
          state_d   = ST_TX_GAP;
        end
      end
      ST_TX_LSB: if (!bus.TX_BUSY) begin
        tx_vld_d  = 1'b1;
        tx_data_d = lsb_q;
        state_d   = two_q ? ST_TX_GAP : ST_TX_END;
      end
      ST_TX_GAP: state_d = ST_TX_MSB;
      ST_TX_MSB: if (!bus.TX_BUSY) begin
        tx_vld_d  = 1'b1;
        tx_data_d = msb_q;
        state_d   = ST_TX_END;
      end
      ST_TX_END: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      lsb_q     <= '0;
      msb_q     <= '0;
      two_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      wr_data_q <= '0;
      fun_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lsb_q     <= lsb_d;
      msb_q     <= msb_d;
      two_q     <= two_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      tx_vld_q  <= tx_vld_d;
      wr_data_q <= wr_data_d;
      fun_q     <= fun_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.RF_ADDR    = addr_q;
  assign bus.RF_WR_EN   = wr_en_q;
  assign bus.RF_WR_DATA = wr_data_q;
  assign bus.RF_RD_EN   = rd_en_q;
  assign bus.ALU_FUN    = fun_q;
  assign bus.ALU_EN     = alu_en_q;
  assign bus.TX_P_DATA  = tx_data_q;
  assign bus.TX_D_VLD   = tx_vld_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb/tb_sys_cmd_ctrl.sv - self-checking bench for sys_cmd_ctrl
`timescale 1ns/1ps
module tb_sys_cmd_ctrl;

  localparam int K_WR = 0, K_RD = 1, K_ALU = 2, K_TX = 3;

  typedef struct { int kind; int a; int d; int cyc; } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sys_cmd_ctrl_if bus ();
  sys_cmd_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_left = 0;
  bit         hold_busy = 1'b0;
  logic [3:0] prev_strb = 4'b0;
  logic [7:0] rf_mem [16];
  logic [7:0] ref_rf [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      default: return {a ^ b, a | b};
    endcase
  endfunction

  always @(posedge CLK) cyc++;

  // Event monitor and simulated register file
  always @(negedge CLK) begin
    logic [3:0] strb;
    strb = {bus.TX_D_VLD, bus.ALU_EN, bus.RF_RD_EN, bus.RF_WR_EN};
    if (RST) begin
      prev_strb = 4'b0;
    end else begin
      if (|strb) begin
        check("strobe_onehot", 32'($countones(strb)), 32'd1);
        check("strobe_single_cycle", 32'(strb & prev_strb), 32'd0);
      end
      if (bus.RF_WR_EN) begin
        obs_q.push_back('{kind: K_WR, a: int'(bus.RF_ADDR), d: int'(bus.RF_WR_DATA), cyc: cyc});
        rf_mem[bus.RF_ADDR] = bus.RF_WR_DATA;
      end
      if (bus.RF_RD_EN) obs_q.push_back('{kind: K_RD, a: int'(bus.RF_ADDR), d: 0, cyc: cyc});
      if (bus.ALU_EN)   obs_q.push_back('{kind: K_ALU, a: 0, d: int'(bus.ALU_FUN), cyc: cyc});
      if (bus.TX_D_VLD) obs_q.push_back('{kind: K_TX, a: 0, d: int'(bus.TX_P_DATA), cyc: cyc});
      prev_strb = strb;
    end
  end

  // Transmitter model: busy for a few cycles after each accepted byte
  always @(negedge CLK) begin
    if (RST) begin
      busy_left = 0;
    end else if (bus.TX_D_VLD) begin
      check("tx_while_busy", 32'(bus.TX_BUSY), 32'd0);
      busy_left = $urandom_range(2, 7);
    end else if (busy_left > 0) begin
      busy_left--;
    end
    bus.TX_BUSY = !RST && (busy_left > 0 || hold_busy);
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    tick();
    bus.RX_D_VLD  = 1'b0;
    repeat ($urandom_range(2, 4)) tick();
  endtask

  task automatic exp_push(input int kind, input int a, input int d);
    exp_q.push_back('{kind: kind, a: a, d: d, cyc: 0});
  endtask

  task automatic wait_obs(input int n, input string tag);
    int t = 0;
    while (obs_q.size() < n && t < 200) begin
      tick();
      t++;
    end
    if (obs_q.size() < n) check({tag, "_timeout"}, 32'(obs_q.size()), 32'(n));
  endtask

  task automatic wait_tx_idle();
    int t = 0;
    while (bus.TX_BUSY && t < 100) begin
      tick();
      t++;
    end
    if (bus.TX_BUSY) check("tx_idle_timeout", 32'(bus.TX_BUSY), 32'd0);
  endtask

  task automatic compare(input string tag);
    repeat (12) tick();
    check({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s ev%0d kind", tag, i), 32'(obs_q[i].kind), 32'(exp_q[i].kind));
      check($sformatf("%s ev%0d addr", tag, i), 32'(obs_q[i].a), 32'(exp_q[i].a));
      check($sformatf("%s ev%0d data", tag, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " RF_ADDR"},    32'(bus.RF_ADDR),    32'd0);
    check({tag, " RF_WR_EN"},   32'(bus.RF_WR_EN),   32'd0);
    check({tag, " RF_WR_DATA"}, 32'(bus.RF_WR_DATA), 32'd0);
    check({tag, " RF_RD_EN"},   32'(bus.RF_RD_EN),   32'd0);
    check({tag, " ALU_FUN"},    32'(bus.ALU_FUN),    32'd0);
    check({tag, " ALU_EN"},     32'(bus.ALU_EN),     32'd0);
    check({tag, " TX_P_DATA"},  32'(bus.TX_P_DATA),  32'd0);
    check({tag, " TX_D_VLD"},   32'(bus.TX_D_VLD),   32'd0);
  endtask

  task automatic run_write(input logic [7:0] ab, input logic [7:0] d);
    exp_push(K_WR, int'(ab[3:0]), int'(d));
    ref_rf[ab[3:0]] = d;
    send_byte(8'hAA);
    send_byte(ab);
    send_byte(d);
    compare("write");
  endtask

  task automatic run_read(input logic [7:0] ab, input bit drop, input bit slow);
    int vc;
    logic [3:0] oa;
    exp_push(K_RD, int'(ab[3:0]), 0);
    exp_push(K_TX, 0, int'(ref_rf[ab[3:0]]));
    send_byte(8'hBB);
    send_byte(ab);
    wait_obs(1, "rd_req");
    if (drop) send_byte(8'hAA);
    wait_tx_idle();
    oa = (obs_q.size() > 0) ? 4'(obs_q[0].a) : 4'd0;
    if (slow) begin
      hold_busy = 1'b1;
      tick();
    end
    bus.RF_RD_DATA     = rf_mem[oa];
    bus.RF_RD_DATA_VLD = 1'b1;
    vc = cyc;
    tick();
    bus.RF_RD_DATA_VLD = 1'b0;
    if (slow) begin
      repeat (3) tick();
      hold_busy = 1'b0;
    end
    wait_obs(2, "rd_resp");
    if (!slow && obs_q.size() >= 2) check("rd_latency", 32'(obs_q[1].cyc - vc), 32'd1);
    compare("read");
  endtask

  task automatic run_alu(input bit ops, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] f, input bit slow);
    int vc;
    int n_pre;
    logic [15:0] res;
    logic [3:0] of;
    n_pre = ops ? 2 : 0;
    if (ops) begin
      exp_push(K_WR, 0, int'(x));
      exp_push(K_WR, 1, int'(y));
      ref_rf[0] = x;
      ref_rf[1] = y;
    end
    exp_push(K_ALU, 0, int'(f[3:0]));
    res = alu_f(f[3:0], ref_rf[0], ref_rf[1]);
    exp_push(K_TX, 0, int'(res[7:0]));
    exp_push(K_TX, 0, int'(res[15:8]));
    if (ops) begin
      send_byte(8'hCC);
      send_byte(x);
      send_byte(y);
    end else begin
      send_byte(8'hDD);
    end
    send_byte(f);
    wait_obs(n_pre + 1, "alu_req");
    wait_tx_idle();
    of = (obs_q.size() > n_pre) ? 4'(obs_q[n_pre].d) : 4'd0;
    if (slow) begin
      hold_busy = 1'b1;
      tick();
    end
    bus.ALU_OUT     = alu_f(of, rf_mem[0], rf_mem[1]);
    bus.ALU_OUT_VLD = 1'b1;
    vc = cyc;
    tick();
    bus.ALU_OUT_VLD = 1'b0;
    if (slow) begin
      repeat (3) tick();
      hold_busy = 1'b0;
    end
    wait_obs(n_pre + 3, "alu_resp");
    if (!slow && obs_q.size() > n_pre + 1) check("alu_latency", 32'(obs_q[n_pre + 1].cyc - vc), 32'd1);
    compare(ops ? "alu_op" : "alu_nop");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bus.RX_P_DATA      = '0;
    bus.RX_D_VLD       = 1'b0;
    bus.RF_RD_DATA     = '0;
    bus.RF_RD_DATA_VLD = 1'b0;
    bus.ALU_OUT        = '0;
    bus.ALU_OUT_VLD    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'($urandom);
      ref_rf[i] = rf_mem[i];
    end

    RST = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    RST = 1'b0;
    tick();

    run_write(8'h0B, 8'h16);
    run_read(8'h0B, 1'b0, 1'b0);
    run_alu(1'b1, 8'hFF, 8'h04, 8'h02, 1'b0);
    run_alu(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    send_byte(8'h55);
    run_read(8'hF3, 1'b0, 1'b0);
    run_read(8'h01, 1'b1, 1'b1);
    run_alu(1'b0, 8'h00, 8'h00, 8'h31, 1'b1);

    // Reset while waiting on the ALU: the late result must not be sent
    send_byte(8'hDD);
    send_byte(8'h05);
    wait_obs(1, "rst_alu_req");
    RST = 1'b1;
    tick();
    check_outputs_zero("midreset");
    RST = 1'b0;
    obs_q.delete();
    exp_q.delete();
    bus.ALU_OUT     = 16'hBEEF;
    bus.ALU_OUT_VLD = 1'b1;
    tick();
    bus.ALU_OUT_VLD = 1'b0;
    compare("post_reset");
    run_write(8'h27, 8'h5A);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
        send_byte(b);
      end
      case ($urandom_range(0, 3))
        0:       run_write(8'($urandom), 8'($urandom));
        1:       run_read(8'($urandom), 1'($urandom), 1'($urandom));
        2:       run_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        default: run_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 1'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
